interposer_arbiter: RTL and testbench
=====================================

# interposer_arbiter

Central bus controller for the multipoint interposer ring. It collects the 4-bit request from every node I/O block and picks one sender per transfer, using round-robin order. It then drives each node's 3-bit control word in sequence: grant-send to the source, then receive to the destination and bypass to every node strictly between them on the ring. It sits beside the ring of node I/O blocks and is the only driver of their control inputs.

## Interface
- NUM_NODES, 8, number of nodes on the ring (2..8)
- ID_W, 3, node-id width; node ids are 0..NUM_NODES-1
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_in  input  4*NUM_NODES  per-node request: slice i = {valid, dest[2:0]} from node i
- ctrl_out  output  3*NUM_NODES  per-node control: slice i = {send, receive, bypass}; 000 = idle
- busy  output  1  high while a transfer occupies the ring (GRANT or DELIVER)
- grant_id  output  ID_W  source id of the current or last transfer
- err_valid  output  1  one-cycle pulse: illegal request rejected
- err_node  output  ID_W  id of the rejected requester, held until the next error
- msg_count  output  16  completed transfers, wraps at 16'hFFFF -> 0

## Operation
- FSM states: IDLE, GRANT, DELIVER, RELEASE.
- Arbitration runs in IDLE and RELEASE.
  - Eligible node: valid=1 and not masked.
  - Search order: rr_ptr, rr_ptr+1, ... mod NUM_NODES. First eligible node wins.
- Winner checks:
  - Legal winner (dest != src and dest < NUM_NODES): latch src and dest, go to GRANT.
  - Illegal winner: no grant. Pulse err_valid, load err_node = src, set mask[src], set rr_ptr = src+1. Stay in IDLE or go to IDLE.
  - mask[i] clears on any cycle where req_in slice i has valid=0.
- GRANT, one cycle:
  - ctrl[src] = 100; every other slice = 000.
  - busy=1; grant_id = src.
- DELIVER, one cycle:
  - ctrl[dest] = 010.
  - ctrl[k] = 001 for every k on the path src+1 .. dest-1 mod NUM_NODES (increasing direction, with wrap).
  - All other slices 000; busy=1.
- RELEASE, one cycle:
  - ctrl all 000; msg_count += 1; rr_ptr = src+1 mod NUM_NODES.
  - Arbitration runs; the just-served src is excluded this cycle.
  - If a legal winner exists, go to GRANT; otherwise go to IDLE.
- Requests are sampled only during arbitration. Changes to req_in during GRANT or DELIVER are ignored; the latched src and dest are used.
- Adjacent nodes (dest = src+1) produce no bypass slices.
- NUM_NODES < 8: req_in bits above 4*NUM_NODES do not exist. A dest id >= NUM_NODES is illegal.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE; ctrl_out=0; busy=0; grant_id=0; err_valid=0; err_node=0.
  - msg_count=0; rr_ptr=0; mask=0.
- All outputs are registered.
- Latency: legal request present in IDLE at edge t -> GRANT visible after edge t, DELIVER after t+1, RELEASE after t+2.
- Back-to-back throughput: one transfer per 3 cycles (GRANT, DELIVER, RELEASE repeating).
- msg_count increments on the edge that enters RELEASE + 1, i.e. it is visible one cycle after RELEASE.
- Simultaneous requests from all nodes are served in strict rotation starting at rr_ptr.
- An illegal request and legal requests in the same cycle:
  - If the illegal one wins, the error costs one cycle.
  - The legal requests win on the next arbitration.
- Reset asserted mid-transfer: ctrl_out goes to 000 immediately (asynchronously). The transfer is dropped and not counted.

## Test plan
- Reset, then node 0 requests dest 6 (req slice0 = 4'b1110), NUM_NODES=8:
  - GRANT: ctrl0 = 100.
  - DELIVER: ctrl6 = 010; ctrl1..5 = 001; ctrl7 = 000.
  - After RELEASE: msg_count = 1.
- All 8 nodes request simultaneously (node i dest i+1 mod 8), rr_ptr=0:
  - Grants occur in order 0,1,...,7, each 3 cycles apart.
  - msg_count = 8 after 24 cycles.
- Wrap path: node 6 to dest 1 -> DELIVER has ctrl1 = 010 and ctrl7, ctrl0 = 001.
- Illegal request: node 3 dest 3, valid held high:
  - Exactly one err_valid pulse with err_node = 3; no grant.
  - Node 3 stays masked until valid drops. It is granted after reasserting with dest 5.
- req_in of the winner changes to dest 2 during GRANT -> DELIVER still targets the originally latched dest.
- reset pulled low during DELIVER -> ctrl_out = 0 in the same cycle, busy = 0, msg_count = 0, and the next grant goes to the lowest-id requester.

Source files
------------

// File: rtl/interposer_arbiter_if.sv
// Request/control bundle between the ring arbiter and the node I/O blocks.
// master = arbiter side, slave = ring/node side.
interface interposer_arbiter_if #(
  parameter int unsigned NUM_NODES = 8,
  parameter int unsigned ID_W      = 3
);
  logic [4*NUM_NODES-1:0] req_in;
  logic [3*NUM_NODES-1:0] ctrl_out;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;
  logic                   err_valid;
  logic [ID_W-1:0]        err_node;
  logic [15:0]            msg_count;

  modport master (
    input  req_in,
    output ctrl_out, busy, grant_id, err_valid, err_node, msg_count
  );

  modport slave (
    output req_in,
    input  ctrl_out, busy, grant_id, err_valid, err_node, msg_count
  );
endinterface

// File: rtl/interposer_arbiter.sv
// Round-robin ring arbiter: picks one sender, then drives send, receive and
// bypass control words along the increasing-id path to the destination.
module interposer_arbiter #(
  parameter int unsigned NUM_NODES = 8,
  parameter int unsigned ID_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  interposer_arbiter_if.master bus
);
  localparam int unsigned DW = ID_W + 1;

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER, RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        src_q, src_d, dest_q, dest_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_q, grant_d, err_node_q, err_node_d;
  logic [NUM_NODES-1:0]   mask_q, mask_d, node_valid;
  logic [2:0]             node_dest [NUM_NODES];
  logic [3*NUM_NODES-1:0] ctrl_q, ctrl_d;
  logic                   busy_q, busy_d, err_valid_q, err_valid_d;
  logic [15:0]            msg_count_q, msg_count_d;

  logic                   win_found, win_legal;
  logic [ID_W-1:0]        win_id, cand;
  logic [DW-1:0]          cand_sum, path_len;
  logic [2:0]             win_dest;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (32'(id) + 32'd1 >= NUM_NODES) return '0;
    return id + ID_W'(1);
  endfunction

  // Hops from 'from' to 'to' going in increasing-id direction around the ring.
  function automatic logic [DW-1:0] ring_dist(input logic [ID_W-1:0] from,
                                              input logic [ID_W-1:0] to);
    if (to >= from) return {1'b0, to} - {1'b0, from};
    return {1'b0, to} + DW'(NUM_NODES) - {1'b0, from};
  endfunction

  assign path_len = ring_dist(src_q, dest_q);

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
    assign node_valid[g]    = bus.req_in[4*g+3];
    assign node_dest[g]     = bus.req_in[4*g +: 3];
    assign ctrl_d[3*g+2]    = (state_d == GRANT)   && (src_d  == ID_W'(g));
    assign ctrl_d[3*g+1]    = (state_d == DELIVER) && (dest_q == ID_W'(g));
    assign ctrl_d[3*g]      = (state_d == DELIVER) &&
                              (ring_dist(src_q, ID_W'(g)) != '0) &&
                              (ring_dist(src_q, ID_W'(g)) <  path_len);
  end

  // rr_ptr already points past the last source when RELEASE arbitrates.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + DW'(i);
      if (cand_sum >= DW'(NUM_NODES)) cand_sum = cand_sum - DW'(NUM_NODES);
      cand = cand_sum[ID_W-1:0];
      if (!win_found && node_valid[cand] && !mask_q[cand] &&
          !(state_q == RELEASE && cand == src_q)) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_dest  = node_dest[win_id];
    win_legal = (ID_W'(win_dest) != win_id) && (32'(win_dest) < NUM_NODES);
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dest_d      = dest_q;
    rr_ptr_d    = rr_ptr_q;
    mask_d      = mask_q & node_valid;
    err_valid_d = 1'b0;
    err_node_d  = err_node_q;
    msg_count_d = msg_count_q;
    case (state_q)
      GRANT:   state_d = DELIVER;
      DELIVER: begin
        state_d  = RELEASE;
        rr_ptr_d = next_id(src_q);
      end
      default: begin
        if (state_q == RELEASE) msg_count_d = msg_count_q + 16'd1;
        state_d = IDLE;
        if (win_found) begin
          if (win_legal) begin
            src_d   = win_id;
            dest_d  = ID_W'(win_dest);
            state_d = GRANT;
          end else begin
            err_valid_d    = 1'b1;
            err_node_d     = win_id;
            mask_d[win_id] = 1'b1;
            rr_ptr_d       = next_id(win_id);
          end
        end
      end
    endcase
    busy_d  = (state_d == GRANT) || (state_d == DELIVER);
    grant_d = (state_d == GRANT) ? src_d : grant_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dest_q      <= '0;
      rr_ptr_q    <= '0;
      mask_q      <= '0;
      ctrl_q      <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      err_valid_q <= 1'b0;
      err_node_q  <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      rr_ptr_q    <= rr_ptr_d;
      mask_q      <= mask_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      err_valid_q <= err_valid_d;
      err_node_q  <= err_node_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign bus.ctrl_out  = ctrl_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_node  = err_node_q;
  assign bus.msg_count = msg_count_q;
endmodule

// File: tb/tb_interposer_arbiter.sv
// Bench for interposer_arbiter: directed ring scenarios plus random requests,
// all outputs compared every cycle against a transfer-level reference model.
module tb_interposer_arbiter;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*N-1:0] req;

  int n_checks = 0;
  int n_fail   = 0;

  interposer_arbiter_if #(.NUM_NODES(N), .ID_W(IW)) bus ();
  interposer_arbiter    #(.NUM_NODES(N), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.req_in = req;
  always #5 clk = ~clk;

  // Reference model: ph 0 = arbitrating idle, 1 = grant, 2 = deliver, 3 = release
  int ph, m_src, m_dest, m_rr, m_cnt, m_grant, m_errn;
  bit m_errv;
  bit m_mask [N];

  task automatic model_reset();
    ph = 0; m_src = 0; m_dest = 0; m_rr = 0; m_cnt = 0;
    m_grant = 0; m_errn = 0; m_errv = 0;
    for (int n = 0; n < N; n++) m_mask[n] = 0;
  endtask

  task automatic model_step();
    bit v [N];
    int d [N];
    int nph;
    int win;
    for (int n = 0; n < N; n++) begin
      v[n] = req[4*n+3];
      d[n] = int'(req[4*n +: 3]);
    end
    m_errv = 0;
    win    = -1;
    nph    = 0;
    if (ph == 1) nph = 2;
    else if (ph == 2) begin
      nph  = 3;
      m_rr = (m_src + 1) % N;
    end else begin
      if (ph == 3) m_cnt = (m_cnt + 1) % 65536;
      for (int i = 0; i < N; i++) begin
        int n;
        n = (m_rr + i) % N;
        if (win < 0 && v[n] && !m_mask[n] && !(ph == 3 && n == m_src)) win = n;
      end
    end
    for (int n = 0; n < N; n++) if (!v[n]) m_mask[n] = 0;
    if (win >= 0) begin
      if (d[win] != win && d[win] < N) begin
        m_src = win; m_dest = d[win]; m_grant = win; nph = 1;
      end else begin
        m_errv = 1; m_errn = win; m_mask[win] = 1; m_rr = (win + 1) % N;
      end
    end
    ph = nph;
  endtask

  function automatic logic [3*N-1:0] exp_ctrl();
    logic [3*N-1:0] r;
    r = '0;
    if (ph == 1) r[3*m_src+2] = 1'b1;
    if (ph == 2) begin
      r[3*m_dest+1] = 1'b1;
      for (int s = 1; s < (m_dest - m_src + N) % N; s++) r[3*((m_src + s) % N)] = 1'b1;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".ctrl"},  32'(bus.ctrl_out),  32'(exp_ctrl()));
    check_eq({tag, ".busy"},  32'(bus.busy),      32'(ph == 1 || ph == 2));
    check_eq({tag, ".gid"},   32'(bus.grant_id),  32'(m_grant));
    check_eq({tag, ".errv"},  32'(bus.err_valid), 32'(m_errv));
    check_eq({tag, ".errn"},  32'(bus.err_node),  32'(m_errn));
    check_eq({tag, ".count"}, 32'(bus.msg_count), 32'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (reset) model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs, busy_seen, seen, gid;
    int order [$];

    reset = 1'b0;
    req   = '0;
    model_reset();
    #12;
    compare_all("por");
    check_eq("por_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_eq("por_count", 32'(bus.msg_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle("idle");

    // node 0 -> dest 6
    req[3:0] = 4'b1110;
    cycle("d6_grant");
    check_eq("d6_grant_ctrl", 32'(bus.ctrl_out), 32'h000004);
    req = '0;
    cycle("d6_deliver");
    check_eq("d6_deliver_ctrl", 32'(bus.ctrl_out), 32'h089248);
    cycle("d6_release");
    cycle("d6_after");
    check_eq("d6_count", 32'(bus.msg_count), 32'd1);

    // all nodes request, node i -> i+1
    apply_reset();
    for (int n = 0; n < N; n++) req[4*n +: 4] = {1'b1, 3'((n + 1) % N)};
    for (int c = 0; c < 24; c++) begin
      cycle("all");
      if (bus.busy && bus.ctrl_out[3*bus.grant_id+2]) order.push_back(int'(bus.grant_id));
    end
    req = '0;
    cycle("all_end");
    check_eq("all_grants", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size(); i++) check_eq("all_order", 32'(order[i]), 32'(i));
    check_eq("all_count", 32'(bus.msg_count), 32'd8);
    repeat (2) cycle("idle");

    // wrap path: node 6 -> dest 1
    req[27:24] = 4'b1001;
    cycle("wrap_grant");
    req = '0;
    cycle("wrap_deliver");
    check_eq("wrap_ctrl", 32'(bus.ctrl_out), 32'h200011);
    repeat (3) cycle("idle");

    // illegal: node 3 -> dest 3, held high
    req[15:12] = 4'b1011;
    errs = 0; busy_seen = 0;
    repeat (6) begin
      cycle("illegal");
      if (bus.err_valid) errs++;
      if (bus.busy) busy_seen++;
    end
    check_eq("illegal_pulses", 32'(errs), 32'd1);
    check_eq("illegal_node", 32'(bus.err_node), 32'd3);
    check_eq("illegal_nogrant", 32'(busy_seen), 32'd0);
    req[15] = 1'b0;
    cycle("unmask");
    req[15:12] = 4'b1101;
    seen = 0; gid = -1;
    for (int c = 0; c < 6 && !seen; c++) begin
      cycle("regrant");
      if (bus.busy) begin seen = 1; gid = int'(bus.grant_id); req = '0; end
    end
    check_eq("regrant_seen", 32'(seen), 32'd1);
    check_eq("regrant_id", 32'(gid), 32'd3);
    repeat (4) cycle("idle");

    // dest changes during GRANT must be ignored
    req[19:16] = 4'b1111;
    cycle("latch_grant");
    req[19:16] = 4'b1010;
    cycle("latch_deliver");
    check_eq("latch_ctrl", 32'(bus.ctrl_out), 32'h448000);
    req = '0;
    repeat (4) cycle("idle");

    // asynchronous reset during DELIVER
    req[7:4]   = 4'b1010;
    req[23:20] = 4'b1000;
    cycle("rst_grant");
    cycle("rst_deliver");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    check_eq("rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_count", 32'(bus.msg_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0; gid = -1;
    for (int c = 0; c < 6 && !seen; c++) begin
      cycle("rst_next");
      if (bus.busy) begin seen = 1; gid = int'(bus.grant_id); req = '0; end
    end
    check_eq("rst_next_seen", 32'(seen), 32'd1);
    check_eq("rst_next_id", 32'(gid), 32'd1);
    repeat (4) cycle("idle");

    // random traffic
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < N; n++)
        if ($urandom_range(3) == 0) req[4*n +: 4] = 4'($urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
